// File: rtl/dcache_ctrl_pkg.sv
// Shared definitions for the direct-mapped write-back data cache: FSM encoding,
// line geometry and word select/merge helpers.
package dcache_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  localparam int WORD_W     = 32;
  localparam int LINE_WORDS = 4;
  localparam int LINE_W     = WORD_W * LINE_WORDS;
  localparam int OFF_LSB    = 2;
  localparam int OFF_W      = 2;
  localparam int IDX_LSB    = 4;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [OFF_W-1:0]  off);
    return line[{off, 5'b0} +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] line_merge(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  off,
                                                   input logic [WORD_W-1:0] word);
    logic [LINE_W-1:0] res;
    res = line;
    res[{off, 5'b0} +: WORD_W] = word;
    return res;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the data cache. Reads are asynchronous at idx;
// only valid and dirty are reset, tags and data power up unknown.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = 4,
  parameter int TAG_W    = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  output logic [TAG_W-1:0]  tag_out,
  output logic              valid_out,
  output logic              dirty_out,
  output logic [LINE_W-1:0] line_out,
  input  logic              word_we,
  input  logic [OFF_W-1:0]  word_off,
  input  logic [WORD_W-1:0] word_data,
  input  logic              line_we,
  input  logic [TAG_W-1:0]  line_tag,
  input  logic [LINE_W-1:0] line_data,
  input  logic              dirty_clr
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [NUM_SETS-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];

  assign tag_out   = tag_q[idx];
  assign valid_out = valid_q[idx];
  assign dirty_out = dirty_q[idx];
  assign line_out  = data_q[idx];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (line_we) begin
      valid_d[idx] = 1'b1;
      dirty_d[idx] = 1'b0;
    end
    if (dirty_clr) dirty_d[idx] = 1'b0;
    if (word_we)   dirty_d[idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (line_we) begin
      tag_q[idx]  <= line_tag;
      data_q[idx] <= line_data;
    end else if (word_we) begin
      data_q[idx] <= line_merge(data_q[idx], word_off, word_data);
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: hit path,
// victim write-back / line fill FSM, line-wide memory handshake and counters.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int NUM_SETS = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              is_input_valid,
  input  logic              mem_rw,
  input  logic [31:0]       addr,
  input  logic [31:0]       din,
  output logic [31:0]       dout,
  output logic              is_hit,
  output logic              is_ready,
  output logic              is_output_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - IDX_LSB - IDX_W;

  // Memory handshake: mem_req rises with a transfer and is held, together with
  // mem_we/mem_addr/mem_wdata, until the cycle mem_ack pulses; a write-back
  // flows straight into its fill without mem_req dropping in between.
  state_e      state_q, state_d;
  logic        retry_q, retry_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic [OFF_W-1:0]  off;
  logic [TAG_W-1:0]  arr_tag;
  logic              arr_valid, arr_dirty;
  logic [LINE_W-1:0] arr_line;
  logic              hit, in_idle;
  logic              word_we, line_we, dirty_clr;

  assign idx     = addr[IDX_LSB +: IDX_W];
  assign req_tag = addr[31 -: TAG_W];
  assign off     = addr[OFF_LSB +: OFF_W];

  dcache_array #(
    .NUM_SETS (NUM_SETS),
    .IDX_W    (IDX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk       (clk),
    .rst_n     (reset),
    .idx       (idx),
    .tag_out   (arr_tag),
    .valid_out (arr_valid),
    .dirty_out (arr_dirty),
    .line_out  (arr_line),
    .word_we   (word_we),
    .word_off  (off),
    .word_data (din),
    .line_we   (line_we),
    .line_tag  (req_tag),
    .line_data (mem_rdata),
    .dirty_clr (dirty_clr)
  );

  assign hit             = is_input_valid && arr_valid && (arr_tag == req_tag);
  assign in_idle         = (state_q == IDLE);
  assign is_hit          = in_idle && hit;
  assign is_ready        = in_idle;
  assign is_output_valid = in_idle && (!is_input_valid || hit);
  assign dout            = is_hit ? line_word(arr_line, off) : '0;

  assign mem_req    = mem_req_q;
  assign mem_we     = (state_q == WRITEBACK);
  assign mem_wdata  = arr_line;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

  always_comb begin
    mem_addr = '0;
    if (state_q == WRITEBACK)     mem_addr = {arr_tag, idx, 4'b0};
    else if (state_q == ALLOCATE) mem_addr = {addr[31:4], 4'b0};
  end

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    word_we    = 1'b0;
    line_we    = 1'b0;
    dirty_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!is_input_valid) begin
          retry_d = 1'b0;
        end else if (hit) begin
          word_we = mem_rw;
          // The first hit after a fill is the replay of an already counted miss.
          if (retry_q) retry_d   = 1'b0;
          else         hit_cnt_d = hit_cnt_q + 32'd1;
        end else begin
          miss_cnt_d = miss_cnt_q + 32'd1;
          state_d    = (arr_valid && arr_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (mem_ack) begin
          dirty_clr = 1'b1;
          state_d   = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (mem_ack) begin
          line_we = 1'b1;
          retry_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    mem_req_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      retry_q    <= 1'b0;
      mem_req_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      mem_req_q  <= mem_req_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: cold miss, write hit, dirty eviction, reset
// during a fill, idle behaviour and write-allocate with later write-back.
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         is_input_valid;
  logic         mem_rw;
  logic [31:0]  addr;
  logic [31:0]  din;
  logic [31:0]  dout;
  logic         is_hit;
  logic         is_ready;
  logic         is_output_valid;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  int     checks = 0;
  int     errors = 0;
  longint t0, t1;

  localparam logic [127:0] LINE_A = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] LINE_B = 128'h88888888_77777777_66666666_55555555;
  localparam logic [127:0] LINE_C = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
  localparam logic [127:0] LINE_D = 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A;

  dcache_ctrl #(.NUM_SETS(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .mem_rw          (mem_rw),
    .addr            (addr),
    .din             (din),
    .dout            (dout),
    .is_hit          (is_hit),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack),
    .hit_count       (hit_count),
    .miss_count      (miss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory model: ack arrives lat cycles after the request is seen.
  task automatic serve(input int lat, input logic [127:0] rdata);
    repeat (lat) tick();
    mem_rdata = rdata;
    mem_ack   = 1'b1;
    tick();
    mem_ack   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; is_input_valid = 1'b0; mem_rw = 1'b0; addr = '0; din = '0;
    mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) tick();
    check("rst_ready", is_ready, 1);
    check("rst_ov", is_output_valid, 1);
    check("rst_hit", is_hit, 0);
    check("rst_dout", dout, 0);
    check("rst_req", mem_req, 0);
    check("rst_hitcnt", hit_count, 0);
    check("rst_misscnt", miss_count, 0);
    reset = 1'b1;
    tick();

    // Cold read miss with a clean fill
    is_input_valid = 1'b1; mem_rw = 1'b0; addr = 32'h100;
    t0 = $time;
    #1;
    check("cold_ov", is_output_valid, 0);
    check("cold_ready", is_ready, 1);
    check("cold_hit", is_hit, 0);
    tick();
    check("cold_req", mem_req, 1);
    check("cold_we", mem_we, 0);
    check("cold_addr", mem_addr, 32'h100);
    check("cold_busy", is_ready, 0);
    check("cold_miss", miss_count, 1);
    serve(4, LINE_A);
    t1 = $time;
    check("clean_latency", (t1 - t0) / 10, 6);
    check("cold_fill_hit", is_hit, 1);
    check("cold_fill_dout", dout, 32'h11111111);
    check("cold_fill_ov", is_output_valid, 1);
    check("cold_req_drop", mem_req, 0);
    check("cold_fill_hitcnt", hit_count, 0);
    tick();
    check("retry_nocount", hit_count, 0);

    // Write hit, then read it back
    mem_rw = 1'b1; addr = 32'h104; din = 32'hDEADBEEF;
    #1;
    check("wr_ov", is_output_valid, 1);
    check("wr_hit", is_hit, 1);
    check("wr_noreq", mem_req, 0);
    tick();
    check("wr_hitcnt", hit_count, 1);
    mem_rw = 1'b0;
    #1;
    check("rd_dout", dout, 32'hDEADBEEF);
    check("rd_hitcnt", hit_count, 1);
    tick();
    check("rd_hitcnt2", hit_count, 2);

    // Dirty conflict on index 0
    addr = 32'h200;
    t0 = $time;
    #1;
    check("dirty_ov", is_output_valid, 0);
    tick();
    check("wb_req", mem_req, 1);
    check("wb_we", mem_we, 1);
    check("wb_addr", mem_addr, 32'h100);
    check("wb_data1", mem_wdata[63:32], 32'hDEADBEEF);
    check("wb_data0", mem_wdata[31:0], 32'h11111111);
    check("wb_miss", miss_count, 2);
    serve(4, '0);
    check("alloc_req", mem_req, 1);
    check("alloc_we", mem_we, 0);
    check("alloc_addr", mem_addr, 32'h200);
    serve(4, LINE_B);
    t1 = $time;
    check("dirty_latency", (t1 - t0) / 10, 11);
    check("dirty_dout", dout, 32'h55555555);
    check("dirty_ov_done", is_output_valid, 1);
    tick();
    check("dirty_hitcnt", hit_count, 2);

    // Reset in the middle of a fill
    addr = 32'h300;
    #1;
    tick();
    check("pre_rst_req", mem_req, 1);
    check("pre_rst_addr", mem_addr, 32'h300);
    check("pre_rst_we", mem_we, 0);
    tick();
    reset = 1'b0; is_input_valid = 1'b0;
    #1;
    check("midrst_req", mem_req, 0);
    check("midrst_ready", is_ready, 1);
    check("midrst_ov", is_output_valid, 1);
    check("midrst_hit", is_hit, 0);
    check("midrst_dout", dout, 0);
    check("midrst_hitcnt", hit_count, 0);
    check("midrst_misscnt", miss_count, 0);
    tick();
    reset = 1'b1; is_input_valid = 1'b1; mem_rw = 1'b0; addr = 32'h200;
    #1;
    check("postrst_ov", is_output_valid, 0);
    tick();
    check("postrst_miss", miss_count, 1);
    check("postrst_we", mem_we, 0);
    check("postrst_addr", mem_addr, 32'h200);
    serve(2, LINE_B);
    check("postrst_dout", dout, 32'h55555555);
    tick();

    // Idle cycles, including a stray ack
    is_input_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mem_ack = (i == 5);
      tick();
      check("idle_ready", is_ready, 1);
      check("idle_ov", is_output_valid, 1);
      check("idle_hit", is_hit, 0);
    end
    mem_ack = 1'b0;
    check("idle_req", mem_req, 0);
    check("idle_hitcnt", hit_count, 0);
    check("idle_misscnt", miss_count, 1);

    // Write miss on a clean line, then evict it
    is_input_valid = 1'b1; mem_rw = 1'b1; addr = 32'h300; din = 32'h5;
    #1;
    check("wmiss_ov", is_output_valid, 0);
    tick();
    check("wmiss_we", mem_we, 0);
    check("wmiss_addr", mem_addr, 32'h300);
    check("wmiss_miss", miss_count, 2);
    serve(3, LINE_C);
    check("wmiss_ov_done", is_output_valid, 1);
    check("wmiss_hit", is_hit, 1);
    tick();
    check("wmiss_hitcnt", hit_count, 0);
    mem_rw = 1'b0;
    #1;
    check("wmiss_rd", dout, 32'h5);
    tick();
    check("wmiss_rd_hitcnt", hit_count, 1);
    addr = 32'h400;
    #1;
    check("evict_ov", is_output_valid, 0);
    tick();
    check("evict_we", mem_we, 1);
    check("evict_addr", mem_addr, 32'h300);
    check("evict_data0", mem_wdata[31:0], 32'h5);
    check("evict_data1", mem_wdata[63:32], 32'hBBBBBBBB);
    check("evict_miss", miss_count, 3);
    serve(2, '0);
    check("evict_alloc_we", mem_we, 0);
    check("evict_alloc_addr", mem_addr, 32'h400);
    serve(2, LINE_D);
    check("evict_dout", dout, 32'h0A0A0A0A);
    tick();
    is_input_valid = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
